// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage with IF/ID pipeline register.
// Fetches over a req/ack handshake; handles stall, flush, redirect and outstanding requests.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] target_q, target_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] redir_al;
  logic [31:0] pc_plus4;
  logic        deliver;
  logic [31:0] deliver_instr;

  assign redir_al = {redirect_pc[31:2], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  assign imem_req   = (state_q == REQ) || (state_q == DROP);
  assign imem_addr  = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    target_d      = target_q;
    deliver       = 1'b0;
    deliver_instr = '0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_d = redir_al;
          end else if (flush) begin
            pc_d = pc_q;
          end else if (stall) begin
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            pc_d          = pc_plus4;
          end
        end else if (redirect_valid) begin
          target_d = redir_al;
          state_d  = DROP;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_al;
          state_d = REQ;
        end else if (flush) begin
          state_d = REQ;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          pc_d          = pc_plus4;
          state_d       = REQ;
        end
      end
      DROP: begin
        // The address of the abandoned request must stay on the bus until it is acked.
        if (redirect_valid) begin
          target_d = redir_al;
        end
        if (imem_ack) begin
          pc_d    = redirect_valid ? redir_al : target_q;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (flush) begin
      ifid_instr_d = '0;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      ifid_instr_d = ifid_instr_q;
    end else if (deliver) begin
      ifid_instr_d = deliver_instr;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= PC_RESET;
      hold_instr_q <= '0;
      target_q     <= '0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      target_q     <= target_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model predicts the fetch stream and
// the IF/ID contents each cycle; a separate monitor compares them against the DUT.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        ack_en = 1'b0;

  fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  // Memory: combinational ack gated by the stimulus, data derived from the address.
  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = imem_addr ^ KEY;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  ifid_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: architectural view of the fetch unit.
  logic [31:0] m_pc;
  logic        m_starting;   // first cycle after reset: no request yet
  logic        m_have_word;  // fetched word parked behind a stall
  logic [31:0] m_word;
  logic        m_abandon;    // request outstanding whose data will be thrown away
  logic [31:0] m_target;
  ifid_t       m_ifid;

  function automatic void model_reset();
    m_pc = 32'h0; m_starting = 1'b1; m_have_word = 1'b0; m_word = '0;
    m_abandon = 1'b0; m_target = '0; m_ifid = '0;
  endfunction

  function automatic logic model_req();
    return !m_starting && !m_have_word;
  endfunction

  function automatic void model_step(input logic st, input logic fl, input logic rv,
                                     input logic [31:0] rpc, input logic ack_in);
    logic        got, give;
    logic [31:0] tgt, word, pc4;
    tgt  = rpc & 32'hFFFF_FFFC;
    got  = model_req() && ack_in;
    give = 1'b0;
    word = '0;
    pc4  = m_pc + 32'd4;
    if (m_starting) begin
      m_starting = 1'b0;
    end else if (m_have_word) begin
      if (rv) begin m_pc = tgt; m_have_word = 1'b0; end
      else if (fl) m_have_word = 1'b0;
      else if (!st) begin give = 1'b1; word = m_word; m_pc = pc4; m_have_word = 1'b0; end
    end else if (m_abandon) begin
      if (rv) m_target = tgt;
      if (got) begin m_pc = m_target; m_abandon = 1'b0; end
    end else if (got) begin
      if (rv) m_pc = tgt;
      else if (fl) ;
      else if (st) begin m_have_word = 1'b1; m_word = m_pc ^ KEY; end
      else begin give = 1'b1; word = m_pc ^ KEY; m_pc = pc4; end
    end else if (rv) begin
      m_abandon = 1'b1; m_target = tgt;
    end
    if (fl) m_ifid = '0;
    else if (st) ;
    else if (give) m_ifid = '{valid: 1'b1, instr: word, pc4: pc4};
    else begin m_ifid.valid = 1'b0; m_ifid.instr = '0; end
  endfunction

  // Called at a falling edge: check the fetch bus, drive one cycle of stimulus, predict.
  task automatic cyc(input logic st, input logic fl, input logic rv,
                     input logic [31:0] rpc, input logic ak);
    check("imem_req", {31'b0, imem_req}, {31'b0, model_req()});
    if (model_req()) check("imem_addr", imem_addr, m_pc);
    stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc; ack_en = ak;
    model_step(st, fl, rv, rpc, ak);
    exp_q.push_back(m_ifid);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; ack_en = 1'b0;
    #1;
    check("rst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
    check("rst_ifid_instr", ifid_instr, 32'd0);
    check("rst_ifid_pc4", ifid_pc4, 32'd0);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: IF/ID is presented every cycle; compare just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        ifid_t e;
        e = exp_q.pop_front();
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
        check("ifid_instr", ifid_instr, e.instr);
        check("ifid_pc4", ifid_pc4, e.pc4);
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();
    // Straight-line fetch with a combinational memory.
    cyc(0, 0, 0, 0, 1);
    for (int unsigned i = 0; i < 2; i++) cyc(0, 0, 0, 0, 1);
    // Stall while the word at 8 is acked, then release.
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    // Slow ack with redirect to 0x100 while the request is outstanding.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0000_0100, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    for (int unsigned i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    // Flush plus redirect together with an ack.
    cyc(0, 1, 1, 32'h0000_0040, 1);
    cyc(0, 0, 0, 0, 1);
    // Flush and stall together; misaligned redirect target.
    cyc(1, 1, 0, 0, 1);
    cyc(0, 0, 1, 32'h0000_0103, 1);
    cyc(0, 0, 0, 0, 1);
    // Redirect to the top word: PC+4 wraps to zero.
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    // Enter the abandon state, then reset in the middle of it.
    cyc(0, 0, 1, 32'h0000_0200, 0);
    cyc(0, 0, 0, 0, 0);
    do_reset();
    for (int unsigned i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    // Randomized traffic.
    for (int unsigned i = 0; i < 600; i++) begin
      logic        st, fl, rv, ak;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 20);
      fl  = ($urandom_range(0, 99) < 8);
      rv  = ($urandom_range(0, 99) < 10);
      ak  = ($urandom_range(0, 99) < 65);
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFF);
      cyc(st, fl, rv, rpc, ak);
    end
    cyc(0, 0, 0, 0, 1);
    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
